// File: rtl/wash_phase_timer_if.sv
// Interface between the washing-machine controller and its phase timer.
//   state          controller state code (0 START .. 11 PAUSE)
//   status_weight  load weight 0..3
//   light_running  1 = machine running, 0 = paused
//   timer_out      one-cycle pulse when the current phase expires
//   timer_set      seconds remaining in the current phase
//   water_line     modelled drum water level (0..200)
// master = controller side, slave = timer side.
interface wash_phase_timer_if;
  logic [3:0] state;
  logic [1:0] status_weight;
  logic       light_running;
  logic       timer_out;
  logic [3:0] timer_set;
  logic [7:0] water_line;

  modport master (
    output state, status_weight, light_running,
    input  timer_out, timer_set, water_line
  );

  modport slave (
    input  state, status_weight, light_running,
    output timer_out, timer_set, water_line
  );
endinterface

// File: rtl/wash_phase_timer.sv
// Per-phase countdown and water-level model for the washing-machine controller.
// Loads a duration when the controller enters a timed phase, counts it down one
// second at a time, and emits a one-cycle timer_out pulse one cycle after the
// countdown reaches zero. Models the drum water level during fill/drain phases.
// Ports:
//   clk_N  system clock, all logic on posedge
//   rst    synchronous reset, active-low
//   bus    slave side of wash_phase_timer_if (state/weight/running in,
//          timer_out/timer_set/water_line out)
module wash_phase_timer #(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned WATER_UNIT    = 50,
  parameter int unsigned WASH_SEC      = 9,
  parameter int unsigned SPIN_SEC      = 3,
  parameter int unsigned RINSE_SEC     = 6,
  parameter int unsigned DRY_SEC       = 5
) (
  input  logic              clk_N,
  input  logic              rst,
  wash_phase_timer_if.slave bus
);

  typedef enum logic [3:0] {
    START      = 4'd0,
    XI_1_IN    = 4'd1,
    XI_2_WASH  = 4'd2,
    PIAO_1_OUT = 4'd3,
    PIAO_2_DRY = 4'd4,
    PIAO_3_IN  = 4'd5,
    PIAO_4_RI  = 4'd6,
    TUO_1_OUT  = 4'd7,
    TUO_2_DRY  = 4'd8,
    FINISH     = 4'd9,
    SHUT_DOWN  = 4'd10,
    PAUSE      = 4'd11
  } phase_t;

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [9:0]    UNIT10   = 10'(WATER_UNIT);
  localparam logic [7:0]    UNIT8    = 8'(WATER_UNIT);

  phase_t        cur;
  phase_t        last_phase;
  logic [3:0]    timer_set_q;
  logic [7:0]    water_q;
  logic [PW-1:0] prescaler;
  logic [1:0]    weight_q;
  logic          done;
  logic          pend;
  logic          timer_out_q;

  logic          timed, is_fill, is_drain, idle;
  logic [3:0]    duration;
  logic          load, run, tick;
  logic [9:0]    target, fill_sum;
  logic [7:0]    fill_next, drain_next;

  always_comb begin
    cur      = phase_t'(bus.state);
    timed    = 1'b0;
    is_fill  = 1'b0;
    is_drain = 1'b0;
    idle     = 1'b0;
    duration = '0;
    case (cur)
      XI_1_IN, PIAO_3_IN: begin
        timed    = 1'b1;
        is_fill  = 1'b1;
        duration = {2'b00, bus.status_weight} + 4'd2;
      end
      PIAO_1_OUT, TUO_1_OUT: begin
        timed    = 1'b1;
        is_drain = 1'b1;
        duration = {2'b00, bus.status_weight} + 4'd2;
      end
      XI_2_WASH:  begin timed = 1'b1; duration = 4'(WASH_SEC);  end
      PIAO_2_DRY: begin timed = 1'b1; duration = 4'(SPIN_SEC);  end
      PIAO_4_RI:  begin timed = 1'b1; duration = 4'(RINSE_SEC); end
      TUO_2_DRY:  begin timed = 1'b1; duration = 4'(DRY_SEC);   end
      FINISH, PAUSE: ;
      default:    idle = 1'b1;  // START, SHUT_DOWN and illegal codes
    endcase

    // PAUSE leaves last_phase untouched, so returning to the same phase does not reload.
    load = timed && (cur != last_phase);
    run  = timed && bus.light_running && !done && !load;
    tick = run && (prescaler == PRE_LAST);

    // Fill target uses the weight latched at load, not the live input.
    target     = UNIT10 * ({8'b0, weight_q} + 10'd1);
    fill_sum   = {2'b00, water_q} + UNIT10;
    fill_next  = (fill_sum >= target) ? target[7:0] : fill_sum[7:0];
    drain_next = (water_q <= UNIT8) ? '0 : water_q - UNIT8;
  end

  always_ff @(posedge clk_N) begin
    if (!rst) begin
      timer_out_q <= 1'b0;
      timer_set_q <= '0;
      water_q     <= '0;
      prescaler   <= '0;
      last_phase  <= START;
      weight_q    <= '0;
      done        <= 1'b0;
      pend        <= 1'b0;
    end else begin
      // Expiry is flagged in pend so the pulse lands one cycle after timer_set hits 0.
      timer_out_q <= pend;
      pend        <= 1'b0;
      if (load) begin
        timer_set_q <= duration;
        prescaler   <= '0;
        done        <= 1'b0;
        timer_out_q <= 1'b0;
        last_phase  <= cur;
        weight_q    <= bus.status_weight;
      end else if (run) begin
        if (tick) begin
          prescaler <= '0;
          if (timer_set_q <= 4'd1) begin
            timer_set_q <= '0;
            done        <= 1'b1;
            pend        <= 1'b1;
          end else begin
            timer_set_q <= timer_set_q - 4'd1;
          end
          if (is_fill)
            water_q <= fill_next;
          else if (is_drain)
            water_q <= drain_next;
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end else if (idle) begin
        timer_set_q <= '0;
        water_q     <= '0;
        prescaler   <= '0;
        last_phase  <= START;
        done        <= 1'b0;
        timer_out_q <= 1'b0;
      end
    end
  end

  assign bus.timer_out  = timer_out_q;
  assign bus.timer_set  = timer_set_q;
  assign bus.water_line = water_q;

endmodule
